// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline stage: holds memory-stage results for writeback, with an
// optional two-entry skid buffer so ready_o can be driven from a flop.
module mem_wb_pipe_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned SKID      = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [XLEN-1:0]      pcsrc_i,
    input  logic [XLEN-1:0]      mem_data_read_i,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      offset_i,
    input  logic [REGADDR_W-1:0] write_addr_reg_i,
    input  logic [SEL_W-1:0]     dmem_to_reg_i,
    input  logic                 reg_write_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      mw_pcsrc_o,
    output logic [XLEN-1:0]      mw_mem_data_read_o,
    output logic [XLEN-1:0]      mw_alu_result_o,
    output logic [XLEN-1:0]      mw_offset_o,
    output logic [REGADDR_W-1:0] mw_write_addr_reg_o,
    output logic [SEL_W-1:0]     mw_dmem_to_reg_o,
    output logic                 mw_reg_write_o,
    output logic [XLEN-1:0]      mw_wb_data_o
);

    typedef struct packed {
        logic [XLEN-1:0]      pcsrc;
        logic [XLEN-1:0]      mem_data;
        logic [XLEN-1:0]      alu;
        logic [XLEN-1:0]      offset;
        logic [REGADDR_W-1:0] waddr;
        logic [SEL_W-1:0]     sel;
        logic                 reg_write;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    entry_t in_ent;
    entry_t head;
    logic   head_valid;
    logic   stage_ready;

    assign in_ent = '{pcsrc:     pcsrc_i,
                      mem_data:  mem_data_read_i,
                      alu:       alu_result_i,
                      offset:    offset_i,
                      waddr:     write_addr_reg_i,
                      sel:       dmem_to_reg_i,
                      reg_write: reg_write_i};

    generate
        if (SKID != 0) begin : g_skid
            state_t state_q, state_d;
            entry_t main_q, main_d;
            entry_t skid_q, skid_d;
            logic   ready_q, ready_d;
            logic   in_xfer, out_xfer;

            assign in_xfer  = valid_i & ready_q;
            assign out_xfer = (state_q != EMPTY) & ready_i;

            // Occupancy state, head/skid storage and registered ready.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    ready_q <= ready_d;
                end
            end

            // Next occupancy; ready for next cycle is decided from state_d so
            // ready_o never depends combinationally on ready_i.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_d  = in_ent;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_d = in_ent;
                        end else if (in_xfer) begin
                            skid_d  = in_ent;
                            state_d = TWO;
                        end else if (out_xfer) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_xfer) begin
                            main_d  = skid_q;
                            state_d = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                if (flush_i) begin
                    state_d = EMPTY;
                end
                ready_d = (state_d != TWO);
            end

            assign head        = main_q;
            assign head_valid  = (state_q != EMPTY);
            assign stage_ready = ready_q;
        end else begin : g_single
            entry_t main_q, main_d;
            logic   valid_q, valid_d;
            logic   in_xfer;

            assign stage_ready = ~valid_q | ready_i;
            assign in_xfer     = valid_i & stage_ready;

            // Single holding register.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end

            // Replace on input, drain on output, drop everything on flush.
            always_comb begin
                main_d  = main_q;
                valid_d = valid_q & ~ready_i;
                if (in_xfer) begin
                    main_d  = in_ent;
                    valid_d = 1'b1;
                end
                if (flush_i) begin
                    valid_d = 1'b0;
                end
            end

            assign head       = main_q;
            assign head_valid = valid_q;
        end
    endgenerate

    assign ready_o             = stage_ready;
    assign valid_o             = head_valid;
    assign mw_pcsrc_o          = head.pcsrc;
    assign mw_mem_data_read_o  = head.mem_data;
    assign mw_alu_result_o     = head.alu;
    assign mw_offset_o         = head.offset;
    assign mw_write_addr_reg_o = head.waddr;
    assign mw_dmem_to_reg_o    = head.sel;
    assign mw_reg_write_o      = head_valid & head.reg_write & (head.waddr != '0);

    // Writeback value selection from the head entry.
    always_comb begin
        logic [31:0] sel_ext;
        sel_ext = 32'(head.sel);
        case (sel_ext)
            32'd1:   mw_wb_data_o = head.mem_data;
            32'd2:   mw_wb_data_o = head.pcsrc + XLEN'(4);
            32'd3:   mw_wb_data_o = head.pcsrc + head.offset;
            default: mw_wb_data_o = head.alu;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: skid (SKID=1) and single-entry (SKID=0)
// instances, reference queues as scoreboard, directed then random stimulus.
module tb_mem_wb_pipe_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] off;
        logic [4:0]  wa;
        logic [1:0]  sel;
        logic        rw;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        valid1, ready1, valid0, ready0;
    logic [31:0] pc, mem, alu, off;
    logic [4:0]  wa;
    logic [1:0]  sel;
    logic        rw;

    logic        r1_o, v1_o, rw1_o, r0_o, v0_o, rw0_o;
    logic [31:0] pc1, mem1, alu1, off1, wb1, pc0, mem0, alu0, off0, wb0;
    logic [4:0]  wa1, wa0;
    logic [1:0]  sel1, sel0;

    mem_wb_pipe_stage #(.XLEN(32), .REGADDR_W(5), .SEL_W(2), .SKID(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .flush_i(flush), .valid_i(valid1), .ready_o(r1_o),
        .pcsrc_i(pc), .mem_data_read_i(mem), .alu_result_i(alu), .offset_i(off),
        .write_addr_reg_i(wa), .dmem_to_reg_i(sel), .reg_write_i(rw),
        .valid_o(v1_o), .ready_i(ready1),
        .mw_pcsrc_o(pc1), .mw_mem_data_read_o(mem1), .mw_alu_result_o(alu1),
        .mw_offset_o(off1), .mw_write_addr_reg_o(wa1), .mw_dmem_to_reg_o(sel1),
        .mw_reg_write_o(rw1_o), .mw_wb_data_o(wb1));

    mem_wb_pipe_stage #(.XLEN(32), .REGADDR_W(5), .SEL_W(2), .SKID(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .flush_i(flush), .valid_i(valid0), .ready_o(r0_o),
        .pcsrc_i(pc), .mem_data_read_i(mem), .alu_result_i(alu), .offset_i(off),
        .write_addr_reg_i(wa), .dmem_to_reg_i(sel), .reg_write_i(rw),
        .valid_o(v0_o), .ready_i(ready0),
        .mw_pcsrc_o(pc0), .mw_mem_data_read_o(mem0), .mw_alu_result_o(alu0),
        .mw_offset_o(off0), .mw_write_addr_reg_o(wa0), .mw_dmem_to_reg_o(sel0),
        .mw_reg_write_o(rw0_o), .mw_wb_data_o(wb0));

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Writeback value straight from the selection rules.
    function automatic logic [31:0] ref_wb(input ent_t e);
        case (e.sel)
            2'd0:    return e.alu;
            2'd1:    return e.mem;
            2'd2:    return e.pc + 32'd4;
            default: return e.pc + e.off;
        endcase
    endfunction

    task automatic check_head(input string tag, input ent_t e,
                              input logic [31:0] a_pc, input logic [31:0] a_mem,
                              input logic [31:0] a_alu, input logic [31:0] a_off,
                              input logic [4:0] a_wa, input logic [1:0] a_sel,
                              input logic a_rw, input logic [31:0] a_wb);
        chk({tag, "_pc"},  a_pc,  e.pc);
        chk({tag, "_mem"}, a_mem, e.mem);
        chk({tag, "_alu"}, a_alu, e.alu);
        chk({tag, "_off"}, a_off, e.off);
        chk({tag, "_wa"},  a_wa,  e.wa);
        chk({tag, "_sel"}, a_sel, e.sel);
        chk({tag, "_rw"},  a_rw,  e.rw && (e.wa != 5'd0));
        chk({tag, "_wb"},  a_wb,  ref_wb(e));
    endtask

    // Scoreboard: queues hold accepted entries in order; the head is compared
    // whenever the DUT claims a valid output, then next-edge effects applied.
    ent_t q1[$];
    ent_t q0[$];
    bit   started = 1'b0;

    always @(negedge clk) begin
        ent_t cur;
        bit   exp_r1, exp_r0, in1, out1, in0, out0;
        cur    = '{pc, mem, alu, off, wa, sel, rw};
        exp_r1 = (q1.size() < 2);
        exp_r0 = (q0.size() == 0) || ready0;
        if (started) begin
            chk("valid1", v1_o, q1.size() > 0);
            chk("ready1", r1_o, exp_r1);
            if (q1.size() > 0) check_head("d1", q1[0], pc1, mem1, alu1, off1, wa1, sel1, rw1_o, wb1);
            else chk("d1_rw_idle", rw1_o, 0);
            chk("valid0", v0_o, q0.size() > 0);
            chk("ready0", r0_o, exp_r0);
            if (q0.size() > 0) check_head("d0", q0[0], pc0, mem0, alu0, off0, wa0, sel0, rw0_o, wb0);
            else chk("d0_rw_idle", rw0_o, 0);
        end
        in1  = valid1 && exp_r1;
        out1 = (q1.size() > 0) && ready1;
        in0  = valid0 && exp_r0;
        out0 = (q0.size() > 0) && ready0;
        if (rst) begin
            q1.delete();
            q0.delete();
            started = 1'b1;
        end else if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out1) void'(q1.pop_front());
            if (in1) q1.push_back(cur);
            if (out0) void'(q0.pop_front());
            if (in0) q0.push_back(cur);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        pc  = $urandom;
        mem = $urandom;
        alu = $urandom;
        off = $urandom;
        wa  = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
        sel = 2'($urandom);
        rw  = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        valid1 = 1'b0; ready1 = 1'b1; valid0 = 1'b0; ready0 = 1'b1;
        pc = '0; mem = '0; alu = '0; off = '0; wa = '0; sel = '0; rw = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_fields1", {pc1, mem1}, 64'd0);
        chk("rst_fields1b", {alu1, off1}, 64'd0);
        chk("rst_misc1", {wa1, sel1, rw1_o, v1_o, r1_o}, 64'd1);
        chk("rst_wb1", wb1, 0);
        chk("rst_wb0", wb0, 0);
        chk("rst_misc0", {wa0, sel0, rw0_o, v0_o, r0_o}, 64'd1);

        // Streaming with ready_i held high
        rand_fields(); sel = 2'd0;
        valid1 = 1'b1; alu = 32'h10; step(); chk("stream_10", wb1, 32'h10); chk("stream_rdy", r1_o, 1);
        alu = 32'h20; step(); chk("stream_20", wb1, 32'h20); chk("stream_rdy", r1_o, 1);
        alu = 32'h30; step(); chk("stream_30", wb1, 32'h30); chk("stream_rdy", r1_o, 1);
        valid1 = 1'b0; step();

        // Backpressure fills the skid, then drains in order
        ready1 = 1'b0; valid1 = 1'b1; alu = 32'hA; step();
        alu = 32'hB; step();
        chk("bp_full_rdy", r1_o, 0); chk("bp_head_A", alu1, 32'hA);
        valid1 = 1'b0; ready1 = 1'b1; step();
        chk("bp_head_B", alu1, 32'hB); chk("bp_rdy_back", r1_o, 1); chk("bp_valid", v1_o, 1);
        step(); chk("bp_empty", v1_o, 0);

        // Select decode wraps modulo 2^32
        valid1 = 1'b1; pc = 32'hFFFF_FFFC; off = 32'd8; sel = 2'd2; step();
        chk("sel2_wrap", wb1, 32'h0);
        sel = 2'd3; step();
        chk("sel3_wrap", wb1, 32'h4);

        // Write-enable qualification by destination register
        sel = 2'd0; rw = 1'b1; wa = 5'd0; step(); chk("rw_x0", rw1_o, 0);
        wa = 5'd5; step(); chk("rw_x5", rw1_o, 1);
        valid1 = 1'b0; step();

        // Flush while full, with a new entry offered at the same edge
        ready1 = 1'b0; valid1 = 1'b1; rand_fields(); step(); step();
        chk("fl_full", r1_o, 0);
        flush = 1'b1; step();
        chk("fl_valid", v1_o, 0); chk("fl_ready", r1_o, 1);
        flush = 1'b0; valid1 = 1'b0; step();
        chk("fl_lost", v1_o, 0);

        // Reset while full discards both entries
        valid1 = 1'b1; step(); step();
        chk("rst2_full", r1_o, 0);
        rst = 1'b1; valid1 = 1'b0; ready1 = 1'b1; step();
        rst = 1'b0; step();
        chk("rst2_empty", v1_o, 0); chk("rst2_ready", r1_o, 1);

        // Single-entry stage: combinational ready, replace without bubble
        ready0 = 1'b0; valid0 = 1'b1; rand_fields(); alu = 32'h55; sel = 2'd0; step();
        chk("s0_valid", v0_o, 1);
        alu = 32'h66;
        #1 chk("s0_rdy_low", r0_o, 0);
        ready0 = 1'b1;
        #1 chk("s0_rdy_high", r0_o, 1);
        step();
        chk("s0_replace", alu0, 32'h66); chk("s0_nobubble", v0_o, 1);
        valid0 = 1'b0; step();
        chk("s0_drained", v0_o, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            valid1 = ($urandom % 4) != 0;
            ready1 = ($urandom % 3) != 0;
            valid0 = ($urandom % 4) != 0;
            ready0 = ($urandom % 3) != 0;
            flush  = ($urandom % 64) == 0;
            rst    = ($urandom % 200) == 0;
            step();
        end
        rst = 1'b0; flush = 1'b0; valid1 = 1'b0; valid0 = 1'b0; ready1 = 1'b1; ready0 = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe_stage.md
MEM_WB_PIPE_STAGE -- requirements
Module: mem_wb_pipe_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning): XLEN, 32, datapath width. REGADDR_W, 5, destination-register address width. SEL_W, 2, writeback-select width. SKID, 1, 1 = two-entry skid stage, 0 = single-entry stage.
REQ-002 There SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, clock.
- reset_i, in, 1, synchronous active-high reset.
- flush_i, in, 1, discard all held entries.
- valid_i, in, 1, upstream entry valid.
- ready_o, out, 1, stage can accept.
- pcsrc_i, in, XLEN, PC of instruction.
- mem_data_read_i, in, XLEN, load data.
- alu_result_i, in, XLEN, ALU result.
- offset_i, in, XLEN, PC-relative offset.
- write_addr_reg_i, in, REGADDR_W, destination register.
- dmem_to_reg_i, in, SEL_W, writeback select.
- reg_write_i, in, 1, register write enable.
- valid_o, out, 1, head entry valid.
- ready_i, in, 1, downstream accepts.
- mw_pcsrc_o, mw_mem_data_read_o, mw_alu_result_o, mw_offset_o, out, XLEN each, head-entry fields.
- mw_write_addr_reg_o, out, REGADDR_W, head-entry destination.
- mw_dmem_to_reg_o, out, SEL_W, head-entry select.
- mw_reg_write_o, out, 1, qualified write enable.
- mw_wb_data_o, out, XLEN, selected writeback value.

Function
REQ-004 Input transfer SHALL occur iff valid_i & ready_o at a rising edge; output transfer SHALL occur iff valid_o & ready_i.
REQ-005 SKID=1: occupancy SHALL be tracked as EMPTY, ONE, TWO; head = main register, second = skid register.
REQ-006 EMPTY: an input transfer SHALL load main and move to ONE.
REQ-007 ONE: input only SHALL load skid and move to TWO; output only SHALL move to EMPTY; both SHALL load main with the new entry and stay ONE.
REQ-008 TWO: an output transfer SHALL copy skid into main and move to ONE; no input is accepted.
REQ-009 SKID=1: ready_o SHALL be a registered signal, equal to 0 exactly in TWO, with no combinational path from ready_i.
REQ-010 SKID=0: a single register SHALL be used, and ready_o SHALL be ~valid_o | ready_i (combinational).
REQ-011 Entries SHALL leave in arrival order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-012 Head fields and valid_o SHALL remain stable while valid_o & ~ready_i.
REQ-013 flush_i SHALL force EMPTY at the next edge, overriding any simultaneous input or output transfer; data fields need not clear.
REQ-014 mw_wb_data_o SHALL be combinational from the head entry:
- select 0: alu_result.
- select 1: mem_data_read.
- select 2: pcsrc + 4.
- select 3: pcsrc + offset.
- any other select value: alu_result.
- Sums SHALL be modulo 2^XLEN.
REQ-015 mw_reg_write_o SHALL equal valid_o & head reg_write & (head write_addr != 0).
REQ-016 Latency SHALL be one cycle from input transfer to valid_o when the stage is empty.

Reset
REQ-017 With reset_i high at an edge, the stage SHALL enter EMPTY, and all registered fields SHALL be cleared to 0.
REQ-018 While reset_i is high, inputs SHALL be ignored; reset SHALL have priority over flush and over any transfer.
REQ-019 After reset: valid_o=0, ready_o=1, mw_reg_write_o=0, mw_wb_data_o=0, and all mw_* fields 0.
REQ-020 Reset asserted mid-operation with TWO entries SHALL discard both entries, with no output transfer afterwards.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Streaming, ready_i=1: alu_result_i 0x10, 0x20, 0x30 on consecutive cycles with select 0 -> mw_wb_data_o 0x10, 0x20, 0x30 one cycle later, ready_o held 1.
- Backpressure, SKID=1: ready_i=0, send A then B -> ready_o=0 after B. Raise ready_i -> A then B out in order, ready_o returns 1 after A leaves.
- Select decode: pcsrc_i=0xFFFFFFFC, offset_i=8 -> select 2 gives 0x00000000 and select 3 gives 0x00000004.
- Write qualification: reg_write_i=1, write_addr_reg_i=0 -> mw_reg_write_o=0. Same with addr 5 -> 1.
- Flush in TWO with valid_i=1 at the same edge -> valid_o=0 and ready_o=1 next cycle, and the new entry is lost.
- SKID=0 with ready_i=0 and full -> ready_o=0 in the same cycle. ready_i=1 -> simultaneous replace, no bubble.
